// File: rtl/seq_multiplier_32bit.sv
// Sequential radix-2 shift-add 32x32 multiplier supporting MUL, MULH, MULHSU and MULHU.
// Optional MUL_EARLY_OUT_EN: a zero operand skips CALC/SIGN and finishes in one cycle.
module seq_multiplier_32bit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   localparam logic [1:0] OpMul    = 2'b00;
   localparam logic [1:0] OpMulh   = 2'b01;
   localparam logic [1:0] OpMulhsu = 2'b10;
   localparam logic [1:0] OpMulhu  = 2'b11;

   typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

   state_e      state_q;
   logic [1:0]  op_q;
   logic [63:0] mcand_q;
   logic [31:0] mplier_q;
   logic        neg_q;
   logic [63:0] acc_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;

   logic        a_signed, b_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] acc_step;
   logic [63:0] acc_fin;
   logic [31:0] result_d;

   // Operand sign handling; magnitude of 0x80000000 negates to itself, read as unsigned.
   always_comb begin
      a_signed = (op_i == OpMulh) || (op_i == OpMulhsu);
      b_signed = (op_i == OpMulh);
      a_neg    = a_signed & a_i[31];
      b_neg    = b_signed & b_i[31];
      a_mag    = a_neg ? (~a_i + 32'd1) : a_i;
      b_mag    = b_neg ? (~b_i + 32'd1) : b_i;
   end

   always_comb begin
      acc_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
      acc_fin  = neg_q ? (~acc_q + 64'd1) : acc_q;
      result_d = (op_q == OpMul) ? acc_fin[31:0] : acc_fin[63:32];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         op_q     <= OpMul;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         neg_q    <= 1'b0;
         acc_q    <= 64'd0;
         cnt_q    <= 5'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start_i) begin
                  op_q     <= op_i;
                  mcand_q  <= {32'd0, a_mag};
                  mplier_q <= b_mag;
                  neg_q    <= a_neg ^ b_neg;
                  acc_q    <= 64'd0;
                  cnt_q    <= 5'd0;
                  busy_q   <= 1'b1;
`ifdef MUL_EARLY_OUT_EN
                  if ((a_i == 32'd0) || (b_i == 32'd0)) begin
                     result_q <= 32'd0;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q  <= StCalc;
                  end
`else
                  state_q  <= StCalc;
`endif
               end
            end
            StCalc: begin
               acc_q    <= acc_step;
               mcand_q  <= {mcand_q[62:0], 1'b0};
               mplier_q <= {1'b0, mplier_q[31:1]};
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q <= StSign;
               end
            end
            StSign: begin
               acc_q    <= acc_fin;
               result_q <= result_d;
               done_q   <= 1'b1;
               state_q  <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

   // OpMulhsu and OpMulhu are decoded implicitly through the signedness terms above.
   logic unused_ops;
   assign unused_ops = ^{OpMulhsu, OpMulhu};

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed self-checking bench for seq_multiplier_32bit; cycle 0 is the start acceptance cycle.
module tb_seq_multiplier_32bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int nvec = 0;
   int nerr = 0;

`ifdef MUL_EARLY_OUT_EN
   localparam int ZeroLat = 1;
`else
   localparam int ZeroLat = 34;
`endif

   seq_multiplier_32bit dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   always #5 clk = ~clk;

   // Issues one operation and returns the cycle in which done was seen (-1 on timeout).
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int dcyc);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      dcyc = -1;
      res = 32'hxxxx_xxxx;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            dcyc = c;
            res = result;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp, input int lat);
      logic [31:0] res;
      int dcyc;
      run_op(o, x, y, res, dcyc);
      nvec++;
      if (dcyc !== lat) begin
         nerr++;
         $display("FAIL %s latency: got %0d, expected %0d", name, dcyc, lat);
      end
      nvec++;
      if (res !== exp) begin
         nerr++;
         $display("FAIL %s result: got %h, expected %h", name, res, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      #12;
      nvec++;
      if ({busy, done, result} !== 34'd0) begin
         nerr++;
         $display("FAIL reset_state: busy=%b done=%b result=%h, expected 0/0/0", busy, done,
                  result);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      nvec++;
      if ({busy, done} !== 2'b00) begin
         nerr++;
         $display("FAIL idle_after_reset: busy=%b done=%b, expected 0/0", busy, done);
      end
   endtask

   task automatic test_mul_basic;
      int busy_bad = 0;
      int done_bad = 0;
      logic [31:0] res = 32'd0;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         if (busy !== ((c >= 1) && (c <= 34))) busy_bad++;
         if (done !== (c == 34)) done_bad++;
         if (c == 34) res = result;
         @(negedge clk);
      end
      nvec++;
      if (busy_bad != 0) begin
         nerr++;
         $display("FAIL mul_busy_window: %0d wrong cycles, expected 0", busy_bad);
      end
      nvec++;
      if (done_bad != 0) begin
         nerr++;
         $display("FAIL mul_done_pulse: %0d wrong cycles, expected 0", done_bad);
      end
      nvec++;
      if (res !== 32'h0000_002A) begin
         nerr++;
         $display("FAIL mul_7x6: got %h, expected 0000002a", res);
      end
   endtask

   task automatic test_signed_ops;
      check_op("mulh_min_sq",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      check_op("mulh_m1x2",     2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      check_op("mulhsu_m1xmax", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      check_op("mulhu_max_sq",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      check_op("mul_max_sq",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
      check_op("mulh_m1xm1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      check_op("mulhsu_minx2",  2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      check_op("mulhu_minx2",   2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 34);
   endtask

   task automatic test_ignore_start;
      int dcyc = -1;
      logic [31:0] res = 32'd0;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         start = (c == 5) || (dcyc > 0);
         if (c == 5) begin
            a = 32'd9; b = 32'd9; op = 2'b11;
         end
         if (done && (dcyc < 0)) begin
            dcyc = c;
            res = result;
            start = 1'b1;
         end
         @(negedge clk);
         if (dcyc > 0) break;
      end
      start = 1'b0;
      nvec++;
      if (dcyc !== 34) begin
         nerr++;
         $display("FAIL ignore_latency: got %0d, expected 34", dcyc);
      end
      nvec++;
      if (res !== 32'd3000) begin
         nerr++;
         $display("FAIL ignore_result: got %h, expected %h", res, 32'd3000);
      end
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL ignore_busy_after_done: got %b, expected 0", busy);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if ({busy, done} !== 2'b00) begin
         nerr++;
         $display("FAIL ignore_no_restart: busy=%b done=%b, expected 0/0", busy, done);
      end
   endtask

   task automatic test_reset_abort;
      int done_seen = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd55; b = 32'd77;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({busy, done, result} !== 34'd0) begin
         nerr++;
         $display("FAIL abort_async: busy=%b done=%b result=%h, expected 0/0/0", busy, done,
                  result);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      nvec++;
      if (done_seen != 0) begin
         nerr++;
         $display("FAIL abort_no_done: saw %0d done cycles, expected 0", done_seen);
      end
      check_op("post_reset_mul", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
   endtask

   task automatic test_zero_operand;
      check_op("zero_a",  2'b00, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, ZeroLat);
      check_op("zero_b",  2'b01, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, ZeroLat);
      check_op("nonzero", 2'b11, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 34);
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_signed_ops();
      test_ignore_start();
      test_reset_abort();
      test_zero_operand();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
